// File: rtl/alu_pkg.sv
// Shared opcode and FSM encodings for the ALU / iterative mul-div unit.
// Also holds small helpers that classify opcodes.
package alu_pkg;

  typedef enum logic [4:0] {
    OP_LUI    = 5'd0,
    OP_ADDA   = 5'd1,
    OP_ADD    = 5'd2,
    OP_XOR    = 5'd3,
    OP_OR     = 5'd4,
    OP_AND    = 5'd5,
    OP_SLL    = 5'd6,
    OP_SRL    = 5'd7,
    OP_SRA    = 5'd8,
    OP_SUB    = 5'd9,
    OP_SLT    = 5'd10,
    OP_SLTU   = 5'd11,
    OP_MUL    = 5'd12,
    OP_MULH   = 5'd13,
    OP_MULHSU = 5'd14,
    OP_MULHU  = 5'd15,
    OP_DIV    = 5'd16,
    OP_DIVU   = 5'd17,
    OP_REM    = 5'd18,
    OP_REMU   = 5'd19
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // LUI places a 20-bit immediate above 12 zero bits.
  localparam int LUI_IMM_W = 20;
  localparam int LUI_SHIFT = 12;

  function automatic logic is_iter_op(input logic [4:0] c);
    return (c >= OP_MUL) && (c <= OP_REMU);
  endfunction

  function automatic logic is_div_op(input logic [4:0] c);
    return (c >= OP_DIV) && (c <= OP_REMU);
  endfunction

  function automatic logic is_signed_div(input logic [4:0] c);
    return (c == OP_DIV) || (c == OP_REM);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative multiply (shift-add) and restoring divide, one bit per cycle
// on operand magnitudes; the sign fix-up is applied to the final step.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] result
);

  logic             busy;
  logic [CNT_W-1:0] cnt;
  logic [4:0]       op_r;
  logic [XLEN-1:0]  hi, lo, mcand;
  logic             neg;

  logic             sa, sb, a_neg, b_neg;
  logic [XLEN-1:0]  a_mag, b_mag;
  logic [XLEN:0]    add_sum, rem_sh, sub_diff;
  logic [XLEN-1:0]  hi_nxt, lo_nxt;
  logic [2*XLEN-1:0] prod;

  always_comb begin
    sa    = (op == OP_MULH) || (op == OP_MULHSU) || is_signed_div(op);
    sb    = (op == OP_MULH) || is_signed_div(op);
    a_neg = sa & a[XLEN-1];
    b_neg = sb & b[XLEN-1];
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;
  end

  // hi/lo double as {partial product, multiplier} or {remainder, quotient}.
  always_comb begin
    add_sum  = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
    rem_sh   = {hi, lo[XLEN-1]};
    sub_diff = rem_sh - {1'b0, mcand};
    if (op_r[4]) begin
      if (!sub_diff[XLEN]) begin
        hi_nxt = sub_diff[XLEN-1:0];
        lo_nxt = {lo[XLEN-2:0], 1'b1};
      end else begin
        hi_nxt = rem_sh[XLEN-1:0];
        lo_nxt = {lo[XLEN-2:0], 1'b0};
      end
    end else begin
      hi_nxt = add_sum[XLEN:1];
      lo_nxt = {add_sum[0], lo[XLEN-1:1]};
    end

    prod   = neg ? -{hi_nxt, lo_nxt} : {hi_nxt, lo_nxt};
    result = '0;
    case (op_r)
      OP_MUL:                       result = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: result = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              result = neg ? -lo_nxt : lo_nxt;
      default:                      result = neg ? -hi_nxt : hi_nxt;
    endcase
    done = busy && (cnt == CNT_W'(XLEN - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy  <= 1'b0;
      cnt   <= '0;
      op_r  <= '0;
      hi    <= '0;
      lo    <= '0;
      mcand <= '0;
      neg   <= 1'b0;
    end else if (start) begin
      busy  <= 1'b1;
      cnt   <= '0;
      op_r  <= op;
      hi    <= '0;
      lo    <= op[4] ? a_mag : b_mag;
      mcand <= op[4] ? b_mag : a_mag;
      neg   <= (op == OP_REM) ? a_neg : (a_neg ^ b_neg);
    end else if (busy) begin
      hi  <= hi_nxt;
      lo  <= lo_nxt;
      cnt <= done ? '0 : cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_md_unit.sv
// RV-style ALU with iterative M-extension ops behind a valid/ready handshake.
// Base ops and divide special cases finish in one cycle; the rest take XLEN+1.
module alu_md_unit
  import alu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic [4:0]      Control,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] Out,
  output logic            ovfl
);

  localparam int SH_W = $clog2(XLEN);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e state, state_n;

  logic                   accept, iter_start, div_zero, div_ovf;
  logic                   quick_ovfl, md_done;
  logic [XLEN-1:0]        quick_out, md_result;
  logic signed [XLEN-1:0] a_s, b_s, sum_s, diff_s;
  logic [SH_W-1:0]        shamt;

  always_comb begin
    a_s        = A;
    b_s        = B;
    sum_s      = a_s + b_s;
    diff_s     = a_s - b_s;
    shamt      = B[SH_W-1:0];
    div_zero   = is_div_op(Control) && (B == '0);
    div_ovf    = is_signed_div(Control) && (A == MOST_NEG) && (B == '1);
    quick_out  = '0;
    quick_ovfl = 1'b0;
    case (Control)
      OP_LUI: begin
        quick_out = {XLEN{B[LUI_IMM_W-1]}};
        quick_out[LUI_IMM_W+LUI_SHIFT-1:0] = {B[LUI_IMM_W-1:0], {LUI_SHIFT{1'b0}}};
      end
      OP_ADDA, OP_ADD: begin
        quick_out  = sum_s;
        quick_ovfl = (a_s[XLEN-1] == b_s[XLEN-1]) && (sum_s[XLEN-1] != a_s[XLEN-1]);
      end
      OP_SUB: begin
        quick_out  = diff_s;
        quick_ovfl = (a_s[XLEN-1] != b_s[XLEN-1]) && (diff_s[XLEN-1] != a_s[XLEN-1]);
      end
      OP_XOR:  quick_out = A ^ B;
      OP_OR:   quick_out = A | B;
      OP_AND:  quick_out = A & B;
      OP_SLL:  quick_out = A << shamt;
      OP_SRL:  quick_out = A >> shamt;
      OP_SRA:  quick_out = a_s >>> shamt;
      OP_SLT:  quick_out = {{(XLEN-1){1'b0}}, (a_s < b_s)};
      OP_SLTU: quick_out = {{(XLEN-1){1'b0}}, (A < B)};
      // Divide corner cases resolve here and never enter the iterator.
      OP_DIV, OP_DIVU: begin
        if (div_zero)     quick_out = '1;
        else if (div_ovf) quick_out = A;
      end
      OP_REM, OP_REMU: begin
        if (div_zero) quick_out = A;
      end
      default: ;
    endcase
  end

  always_comb begin
    in_ready   = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
    accept     = in_valid && in_ready;
    iter_start = accept && is_iter_op(Control) && !div_zero && !div_ovf;
    out_valid  = (state == ST_DONE);

    state_n = state;
    case (state)
      ST_BUSY: if (md_done) state_n = ST_DONE;
      ST_IDLE, ST_DONE: begin
        if (accept)                             state_n = iter_start ? ST_BUSY : ST_DONE;
        else if ((state == ST_DONE) && out_ready) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      Out   <= '0;
      ovfl  <= 1'b0;
    end else begin
      state <= state_n;
      if (accept && !iter_start) begin
        Out  <= quick_out;
        ovfl <= quick_ovfl;
      end else if (accept) begin
        ovfl <= 1'b0;
      end else if ((state == ST_BUSY) && md_done) begin
        Out  <= md_result;
        ovfl <= 1'b0;
      end
    end
  end

  alu_muldiv_iter #(
    .XLEN  (XLEN),
    .CNT_W (CNT_W)
  ) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (iter_start),
    .op     (Control),
    .a      (A),
    .b      (B),
    .done   (md_done),
    .result (md_result)
  );

endmodule

// File: tb/tb_alu_md_unit.sv
// Bench for alu_md_unit: directed table, randomized ops against an
// arithmetic reference, and handshake / reset corner sequences.
module tb_alu_md_unit;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            out_ready = 1'b1;
  logic            in_ready, out_valid, ovfl;
  logic [XLEN-1:0] A = '0, B = '0, Out;
  logic [4:0]      Control = '0;

  int n_vec = 0;
  int n_bad = 0;

  alu_md_unit #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Control   (Control),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Out       (Out),
    .ovfl      (ovfl)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  c;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] out;
    logic        ov;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference computed from 64-bit integer arithmetic, not from the datapath.
  function automatic void model(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic ov, output int lat);
    longint      sa, sb, ubs, s;
    logic [63:0] ua, ub, p;
    logic        special;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'h0, a};
    ub  = {32'h0, b};
    ubs = longint'(ub);
    r   = '0;
    ov  = 1'b0;
    special = (b == 32'h0) ||
              ((c == 5'd16 || c == 5'd18) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    lat = ((c >= 5'd12 && c <= 5'd15) || (c >= 5'd16 && c <= 5'd19 && !special)) ? 33 : 1;
    case (int'(c))
      0:  r = {b[19:0], 12'h000};
      1, 2: begin s = sa + sb; r = s[31:0]; ov = (s != longint'($signed(r))); end
      9:  begin s = sa - sb; r = s[31:0]; ov = (s != longint'($signed(r))); end
      3:  r = a ^ b;
      4:  r = a | b;
      5:  r = a & b;
      6:  r = a << b[4:0];
      7:  r = a >> b[4:0];
      8:  begin s = sa >>> b[4:0]; r = s[31:0]; end
      10: r = (sa < sb) ? 32'd1 : 32'd0;
      11: r = (ua < ub) ? 32'd1 : 32'd0;
      12: begin p = sa * sb;  r = p[31:0];  end
      13: begin p = sa * sb;  r = p[63:32]; end
      14: begin p = sa * ubs; r = p[63:32]; end
      15: begin p = ua * ub;  r = p[63:32]; end
      16: begin
        if (b == 0)                                     r = '1;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
        else begin s = sa / sb; r = s[31:0]; end
      end
      17: r = (b == 0) ? 32'hFFFF_FFFF : 32'(ua / ub);
      18: begin
        if (b == 0)                                     r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = '0;
        else begin s = sa % sb; r = s[31:0]; end
      end
      19: r = (b == 0) ? a : 32'(ua % ub);
      default: r = '0;
    endcase
  endfunction

  // Issues one request with out_ready=1; returns result and measured latency.
  task automatic do_op(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic ov, output int lat);
    int n;
    Control  = c;
    A        = a;
    B        = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    r  = Out;
    ov = ovfl;
    @(posedge clk); #1;
  endtask

  initial begin
    vec_t        tbl [18];
    logic [31:0] r, er, ra, rb;
    logic        ov, eov;
    int          lat, elat, seen;
    logic [4:0]  rc;

    tbl[0]  = '{5'd2,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b1, 1};
    tbl[1]  = '{5'd13, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0, 33};
    tbl[2]  = '{5'd12, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE, 1'b0, 33};
    tbl[3]  = '{5'd16, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1};
    tbl[4]  = '{5'd19, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 1'b0, 1};
    tbl[5]  = '{5'd17, 32'd100,       32'd7,         32'd14,        1'b0, 33};
    tbl[6]  = '{5'd9,  32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1};
    tbl[7]  = '{5'd8,  32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 1'b0, 1};
    tbl[8]  = '{5'd10, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1};
    tbl[9]  = '{5'd11, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1};
    tbl[10] = '{5'd0,  32'h1234_5678, 32'h0008_0001, 32'h8000_1000, 1'b0, 1};
    tbl[11] = '{5'd25, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1};
    tbl[12] = '{5'd18, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0, 33};
    tbl[13] = '{5'd14, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 33};
    tbl[14] = '{5'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 33};
    tbl[15] = '{5'd16, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1};
    tbl[16] = '{5'd18, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1};
    tbl[17] = '{5'd6,  32'h0000_0001, 32'h0000_0021, 32'h0000_0002, 1'b0, 1};

    repeat (2) @(posedge clk);
    #1;
    check("rst_out", Out, 0);
    check("rst_ovfl", ovfl, 0);
    check("rst_out_valid", out_valid, 0);
    rst_n = 1'b1;
    check("rst_in_ready", in_ready, 1);

    for (int i = 0; i < 18; i++) begin
      do_op(tbl[i].c, tbl[i].a, tbl[i].b, r, ov, lat);
      check($sformatf("tbl%0d_out", i), r, tbl[i].out);
      check($sformatf("tbl%0d_ovfl", i), ov, tbl[i].ov);
      check($sformatf("tbl%0d_lat", i), lat, tbl[i].lat);
    end

    for (int i = 0; i < 150; i++) begin
      rc = 5'($urandom_range(0, 31));
      case ($urandom_range(0, 7))
        0: ra = 32'h0;
        1: ra = 32'hFFFF_FFFF;
        2: ra = 32'h8000_0000;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0: rb = 32'h0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = 32'h0000_0001;
        default: rb = $urandom;
      endcase
      model(rc, ra, rb, er, eov, elat);
      do_op(rc, ra, rb, r, ov, lat);
      check($sformatf("rnd%0d_op%0d_out", i, rc), r, er);
      check($sformatf("rnd%0d_op%0d_ovfl", i, rc), ov, eov);
      check($sformatf("rnd%0d_op%0d_lat", i, rc), lat, elat);
    end

    // Result held while the consumer stalls.
    out_ready = 1'b0;
    Control = 5'd17; A = 32'd100; B = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    check("stall_lat", lat, 33);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("stall%0d_out", k), Out, 32'd14);
      check($sformatf("stall%0d_valid", k), out_valid, 1);
      check($sformatf("stall%0d_in_ready", k), in_ready, 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    check("stall_release_in_ready", in_ready, 1);
    @(posedge clk); #1;
    check("stall_drained", out_valid, 0);

    // Back-to-back ADD then XOR.
    Control = 5'd2; A = 32'd5; B = 32'd6; in_valid = 1'b1;
    @(posedge clk); #1;
    check("b2b_add_valid", out_valid, 1);
    check("b2b_add_out", Out, 32'd11);
    Control = 5'd3; A = 32'h0000_F0F0; B = 32'h0000_0FF0;
    @(posedge clk); #1;
    check("b2b_xor_valid", out_valid, 1);
    check("b2b_xor_out", Out, 32'h0000_FF00);
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("b2b_drained", out_valid, 0);

    // Reset during a divide aborts it.
    Control = 5'd16; A = 32'd1000; B = 32'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_out", Out, 0);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("abort_no_result", seen, 0);
    do_op(5'd17, 32'd100, 32'd7, r, ov, lat);
    check("after_abort_out", r, 32'd14);
    check("after_abort_lat", lat, 33);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
